// File: rtl/fpu_dual_half_ctl_pkg.sv
// Shared definitions for the dual-half FPU control block: op codes, flag and
// retire-token widths, and the op bit that requests a cross-half transfer.
package fpu_dual_half_ctl_pkg;

  localparam int FLAGW    = 6;
  localparam int RETW_DEF = 14;
  localparam int XBIT_DEF = 10;

  typedef enum logic [7:0] {
    fop_addDH = 8'h20,
    fop_subDH = 8'h21,
    fop_mulDH = 8'h24,
    fop_cmpDH = 8'h2C
  } fop_e;

  // Compares are the only ops whose flags come from the high half.
  localparam logic [7:0] CMPH_CODE = fop_cmpDH;

endpackage

// File: rtl/fpu_dual_half_ctl_tag_pipe.sv
// One issue port's LAT-stage {valid, op, xadd} tag shift register; flush
// kills every valid, while op and xadd shift unconditionally.
module fpu_tag_pipe #(
  parameter int OPW = 21,
  parameter int LAT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_en,
  input  logic [OPW-1:0]           in_op,
  input  logic                     in_xadd,
  output logic [LAT:1]             v_o,
  output logic [LAT:1][OPW-1:0]    op_o,
  output logic [LAT:1]             xadd_o
);

  logic [LAT:1]          v_q;
  logic [LAT:1][OPW-1:0] op_q;
  logic [LAT:1]          xadd_q;

  // NOTE: the op/xadd payload is reset as well as the valids; it is a short
  // register chain rather than a RAM, so clearing it costs nothing and keeps
  // every downstream observation deterministic after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      v_q    <= '0;
      op_q   <= '0;
      xadd_q <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage read its neighbour's
      // pre-edge value, so the loop order does not matter.
      v_q[1]    <= in_en & ~flush;
      op_q[1]   <= in_op;
      xadd_q[1] <= in_xadd;
      for (int k = 2; k <= LAT; k++) begin
        v_q[k]    <= v_q[k-1] & ~flush;
        op_q[k]   <= op_q[k-1];
        xadd_q[k] <= xadd_q[k-1];
      end
    end
  end

  assign v_o    = v_q;
  assign op_o   = op_q;
  assign xadd_o = xadd_q;

endmodule

// File: rtl/fpu_dual_half_ctl.sv
// Control and return-merge block sitting between the FP issue ports and the
// high/low half-datapaths: tag tracking, flag select, retire merge, counters.
module fpu_dual_half_ctl
  import fpu_dual_half_ctl_pkg::*;
#(
  parameter int         NPORT     = 3,
  parameter int         OPW       = 21,
  parameter int         LAT       = 4,
  parameter int         XSTG      = 3,
  parameter int         XBIT      = fpu_dual_half_ctl_pkg::XBIT_DEF,
  parameter logic [7:0] CMPH_CODE = fpu_dual_half_ctl_pkg::CMPH_CODE,
  parameter int         RETW      = fpu_dual_half_ctl_pkg::RETW_DEF,
  parameter int         CNTW      = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [NPORT-1:0]        in_en,
  input  logic [NPORT*OPW-1:0]    in_op,
  input  logic [NPORT-1:0]        in_xadd,
  input  logic [NPORT*FLAGW-1:0]  hflag,
  input  logic [NPORT*FLAGW-1:0]  lflag,
  input  logic [NPORT*RETW-1:0]   ret_h,
  input  logic [NPORT-1:0]        ret_en_h,
  input  logic [NPORT*RETW-1:0]   ret_l,
  input  logic [NPORT-1:0]        ret_en_l,
  output logic [NPORT*RETW-1:0]   ret,
  output logic [NPORT-1:0]        ret_en,
  output logic [NPORT*FLAGW-1:0]  fus,
  output logic [NPORT-1:0]        xreq,
  output logic [NPORT-1:0]        busy,
  output logic [NPORT-1:0]        err
);

  localparam logic [CNTW-1:0] CNT_MAX = '1;
  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

  logic [NPORT-1:0][CNTW-1:0] cnt_q, cnt_d;
  logic [NPORT-1:0]           err_q, err_d;

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    logic [LAT:1]          v;
    logic [LAT:1][OPW-1:0] op;
    logic [LAT:1]          xadd;

    fpu_tag_pipe #(
      .OPW (OPW),
      .LAT (LAT)
    ) u_tag_pipe (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .in_en   (in_en[p]),
      .in_op   (in_op[p*OPW +: OPW]),
      .in_xadd (in_xadd[p]),
      .v_o     (v),
      .op_o    (op),
      .xadd_o  (xadd)
    );

    // Driven purely from tag registers, so xreq has no input-to-output path.
    assign xreq[p] = v[XSTG] & ~xadd[XSTG] & op[XSTG][XBIT];

    assign fus[p*FLAGW +: FLAGW] =
      !v[LAT]                   ? '0 :
      (op[LAT][7:0] == CMPH_CODE) ? hflag[p*FLAGW +: FLAGW] :
                                   lflag[p*FLAGW +: FLAGW];

    assign ret[p*RETW +: RETW] = ret_h[p*RETW +: RETW] | ret_l[p*RETW +: RETW];
    assign ret_en[p]           = ret_en_h[p] | ret_en_l[p];
  end

  // NOTE: next-state values take the current state as their default before
  // any branch, so no path through the block can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    for (int p = 0; p < NPORT; p++) begin
      if (ret_en_h[p] && ret_en_l[p]) err_d[p] = 1'b1;
      if ((in_en[p] && !flush) && !ret_en[p]) begin
        if (cnt_q[p] == CNT_MAX) err_d[p] = 1'b1;
        else                     cnt_d[p] = cnt_q[p] + CNT_ONE;
      end else if (ret_en[p] && !(in_en[p] && !flush)) begin
        if (cnt_q[p] == '0) err_d[p] = 1'b1;
        else                cnt_d[p] = cnt_q[p] - CNT_ONE;
      end
    end
  end

  // Counters survive flush: ops already inside the halves still retire.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  for (genvar p = 0; p < NPORT; p++) begin : g_busy
    assign busy[p] = |cnt_q[p];
  end

  assign err = err_q;

endmodule
